flash_read_sequencer: RTL and testbench

- Upstream stage of flash_out_capture: walks flash word addresses, runs Avalon-MM reads, and returns each 32-bit word on read_data with a one-cycle data_valid.
- Drives data_bus_select so that each word supplies two 16-bit samples, in order.
- Each sample_req advances one sample. A flash read is issued only when a new word is needed.
- Supports forward and reverse playback, wrap-around and restart.

---
 rtl/flash_read_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_flash_read_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_sequencer.sv
// flash_read_sequencer: fetches flash words over Avalon-MM, two 16-bit samples per word.
// Define FLASH_READ_TIMEOUT_EN to add the read watchdog and the timeout_err output.
`timescale 1ns/1ps
module flash_read_sequencer #(
    parameter int                ADDR_W         = 23,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] START_ADDR     = '0,
    parameter logic [ADDR_W-1:0] END_ADDR       = ADDR_W'('h7FFFF),
    parameter int                TIMEOUT_CYCLES = 255
) (
    input  logic              fast_clock,
    input  logic              reset_n,
    input  logic              sample_req,
    input  logic              reverse,
    input  logic              pause,
    input  logic              restart,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic              flash_mem_read,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [DATA_W-1:0] read_data,
    output logic              data_valid,
    output logic              data_bus_select,
    output logic              busy,
`ifdef FLASH_READ_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              req_dropped
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              need_fetch_q, need_fetch_d;
    logic              pending_q, pending_d;
    logic              dropped_q, dropped_d;
    logic              sel_q, sel_d;
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_adv;
    logic              req_acc;

`ifdef FLASH_READ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        fetch_addr_d = fetch_addr_q;
        need_fetch_d = need_fetch_q;
        pending_d    = pending_q;
        dropped_d    = dropped_q;
        sel_d        = sel_q;
        discard_d    = discard_q;
        data_d       = data_q;
`ifdef FLASH_READ_TIMEOUT_EN
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
`endif
        req_acc = sample_req & ~pause & ~restart;

        if (reverse) begin
            addr_adv = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_W'(1);
        end else begin
            addr_adv = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_W'(1);
        end

        // One request may queue behind an active fetch; any more are lost.
        if (state_q != IDLE && req_acc) begin
            if (pending_q) dropped_d = 1'b1;
            else           pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (req_acc || (pending_q && !restart)) begin
                    pending_d = pending_q & req_acc;
                    if (need_fetch_q) begin
                        state_d      = ISSUE;
                        fetch_addr_d = addr_q;
`ifdef FLASH_READ_TIMEOUT_EN
                        cnt_d        = '0;
`endif
                    end else begin
                        sel_d        = ~sel_q;
                        need_fetch_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!flash_mem_waitrequest) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    if (discard_q || restart) begin
                        state_d   = IDLE;
                        discard_d = 1'b0;
                    end else begin
                        data_d  = flash_mem_readdata;
                        sel_d   = reverse;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                need_fetch_d = 1'b0;
                addr_d       = addr_adv;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef FLASH_READ_TIMEOUT_EN
        if (state_q == ISSUE || state_q == WAIT_DATA) begin
            cnt_d = cnt_q + TO_W'(1);
            if (cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
                if (discard_q || restart) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end else begin
                    data_d  = '0;
                    sel_d   = reverse;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end
            end
        end
`endif

        // A read already on the bus completes, but its word is thrown away.
        if (restart) begin
            addr_d       = reverse ? END_ADDR : START_ADDR;
            need_fetch_d = 1'b1;
            pending_d    = 1'b0;
            dropped_d    = 1'b0;
            if (state_d == ISSUE || state_d == WAIT_DATA) discard_d = 1'b1;
`ifdef FLASH_READ_TIMEOUT_EN
            tmo_d        = 1'b0;
`endif
        end
    end

    always_ff @(posedge fast_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= START_ADDR;
            fetch_addr_q <= START_ADDR;
            need_fetch_q <= 1'b1;
            pending_q    <= 1'b0;
            dropped_q    <= 1'b0;
            sel_q        <= 1'b0;
            discard_q    <= 1'b0;
            data_q       <= '0;
`ifdef FLASH_READ_TIMEOUT_EN
            cnt_q        <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            fetch_addr_q <= fetch_addr_d;
            need_fetch_q <= need_fetch_d;
            pending_q    <= pending_d;
            dropped_q    <= dropped_d;
            sel_q        <= sel_d;
            discard_q    <= discard_d;
            data_q       <= data_d;
`ifdef FLASH_READ_TIMEOUT_EN
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign flash_mem_address    = fetch_addr_q;
    assign flash_mem_read       = (state_q == ISSUE);
    assign flash_mem_byteenable = 4'hF;
    assign read_data            = data_q;
    assign data_valid           = (state_q == DONE);
    assign data_bus_select      = sel_q;
    assign busy                 = (state_q != IDLE);
    assign req_dropped          = dropped_q;
`ifdef FLASH_READ_TIMEOUT_EN
    assign timeout_err          = tmo_q;
`endif

endmodule

// File: tb/tb_flash_read_sequencer.sv
// tb_flash_read_sequencer: directed vectors plus multi-cycle sequences
// against a small Avalon flash model with programmable waitrequest and latency.
`timescale 1ns/1ps
module tb_flash_read_sequencer;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam logic [31:0] W0 = 32'hAAAA5555;
    localparam logic [31:0] W1 = 32'hAAAB5554;
    localparam logic [31:0] W3 = 32'hAAA95556;

    logic          fast_clock = 1'b0;
    logic          reset_n    = 1'b0;
    logic          sample_req = 1'b0;
    logic          reverse    = 1'b0;
    logic          pause      = 1'b0;
    logic          restart    = 1'b0;
    logic [AW-1:0] flash_mem_address;
    logic          flash_mem_read;
    logic [3:0]    flash_mem_byteenable;
    logic          flash_mem_waitrequest;
    logic [DW-1:0] flash_mem_readdata = '0;
    logic          flash_mem_readdatavalid = 1'b0;
    logic [DW-1:0] read_data;
    logic          data_valid;
    logic          data_bus_select;
    logic          busy;
    logic          req_dropped;
`ifdef FLASH_READ_TIMEOUT_EN
    logic          timeout_err;
`endif

    int passed = 0;
    int total  = 0;
    int wr_left = 0;
    int lat = 1;
    int rd_cnt_left = 0;
    int dv_count = 0;
    logic [AW-1:0] pend_addr = '0;
    logic [AW-1:0] rd_q[$];

    typedef struct {
        logic          req, pau, rst, rev;
        logic          rd;
        logic [AW-1:0] addr;
        logic          dv;
        logic [31:0]   data;
        logic          sel, bsy, drop;
    } vec_t;
    vec_t tbl[10];

    always #5 fast_clock = ~fast_clock;

    flash_read_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .START_ADDR(23'd0),
        .END_ADDR(23'd3), .TIMEOUT_CYCLES(10)
    ) dut (
        .fast_clock(fast_clock),
        .reset_n(reset_n),
        .sample_req(sample_req),
        .reverse(reverse),
        .pause(pause),
        .restart(restart),
        .flash_mem_address(flash_mem_address),
        .flash_mem_read(flash_mem_read),
        .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdata(flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .read_data(read_data),
        .data_valid(data_valid),
        .data_bus_select(data_bus_select),
        .busy(busy),
`ifdef FLASH_READ_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .req_dropped(req_dropped)
    );

    function automatic logic [31:0] word(input logic [AW-1:0] a);
        return 32'hAAAA5555 ^ {a[15:0], a[15:0]};
    endfunction

    assign flash_mem_waitrequest = flash_mem_read && (wr_left > 0);

    // Flash model: lat = cycles from accepted read to readdatavalid, 0 = never.
    always @(posedge fast_clock) begin
        flash_mem_readdatavalid <= 1'b0;
        if (rd_cnt_left == 1) begin
            flash_mem_readdatavalid <= 1'b1;
            flash_mem_readdata      <= word(pend_addr);
        end
        if (rd_cnt_left > 0) rd_cnt_left <= rd_cnt_left - 1;
        if (flash_mem_read && !flash_mem_waitrequest) begin
            rd_q.push_back(flash_mem_address);
            pend_addr <= flash_mem_address;
            if (lat == 1) begin
                flash_mem_readdatavalid <= 1'b1;
                flash_mem_readdata      <= word(flash_mem_address);
            end else if (lat > 1) begin
                rd_cnt_left <= lat - 1;
            end
        end
        if (flash_mem_read && wr_left > 0) wr_left <= wr_left - 1;
        if (data_valid) dv_count <= dv_count + 1;
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic req_pulse(input logic rev);
        reverse    = rev;
        sample_req = 1'b1;
        @(negedge fast_clock);
        sample_req = 1'b0;
        for (int n = 0; n < 40 && busy; n++) @(negedge fast_clock);
        if (busy) begin
            total++;
            $display("FAIL busy_timeout: busy still %0b after 40 cycles, expected 0", busy);
        end
    endtask

    task automatic restart_pulse(input logic rev);
        reverse = rev;
        restart = 1'b1;
        @(negedge fast_clock);
        restart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dvb;
        int rd_cyc;
        logic stable;

        //            req pau rst rev  rd addr dv  data sel bsy drop
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 23'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 23'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 23'd0, 1'b1, W0,    1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 23'd0, 1'b0, W0,    1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'd0, 1'b0, W0,    1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 23'd1, 1'b0, W0,    1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 23'd1, 1'b0, W0,    1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 23'd1, 1'b1, W1,    1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 23'd1, 1'b0, W1,    1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 23'd1, 1'b0, W1,    1'b0, 1'b0, 1'b0};

        repeat (2) @(negedge fast_clock);
        chk("reset_outputs",
            {flash_mem_read, flash_mem_address, data_valid, read_data,
             data_bus_select, busy, req_dropped}, '0);
        chk("byteenable", flash_mem_byteenable, 4'hF);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            sample_req = tbl[i].req;
            pause      = tbl[i].pau;
            restart    = tbl[i].rst;
            reverse    = tbl[i].rev;
            @(negedge fast_clock);
            chk($sformatf("vec%0d", i),
                {flash_mem_read, flash_mem_address, data_valid, read_data,
                 data_bus_select, busy, req_dropped},
                {tbl[i].rd, tbl[i].addr, tbl[i].dv, tbl[i].data,
                 tbl[i].sel, tbl[i].bsy, tbl[i].drop});
        end
        sample_req = 1'b0;
        pause      = 1'b0;

        // Forward through END_ADDR = 3 and wrap to 0.
        rd_q.delete();
        repeat (6) req_pulse(1'b0);
        chk("fwd_read_count", rd_q.size(), 3);
        chk("fwd_addrs", {rd_q[0], rd_q[1], rd_q[2]}, {23'd2, 23'd3, 23'd0});
        chk("fwd_wrap_data_sel", {read_data, data_bus_select}, {W0, 1'b0});

        // Reverse playback from END_ADDR, wrapping START_ADDR -> END_ADDR.
        restart_pulse(1'b1);
        rd_q.delete();
        req_pulse(1'b1);
        chk("rev_first_word", {read_data, data_bus_select}, {W3, 1'b1});
        req_pulse(1'b1);
        chk("rev_second_half", {data_bus_select, 32'(rd_q.size())}, {1'b0, 32'd1});
        repeat (8) req_pulse(1'b1);
        chk("rev_read_count", rd_q.size(), 5);
        chk("rev_addrs", {rd_q[0], rd_q[1], rd_q[2], rd_q[3], rd_q[4]},
            {23'd3, 23'd2, 23'd1, 23'd0, 23'd3});

        // waitrequest for 5 cycles, three requests during the read.
        restart_pulse(1'b0);
        rd_q.delete();
        dvb     = dv_count;
        wr_left = 5;
        sample_req = 1'b1;
        @(negedge fast_clock);
        rd_cyc = 0;
        stable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (flash_mem_read) begin
                rd_cyc++;
                if (flash_mem_address != 23'd0) stable = 1'b0;
            end
            sample_req = (i < 3);
            @(negedge fast_clock);
        end
        sample_req = 1'b0;
        chk("wr_read_cycles", rd_cyc, 6);
        chk("wr_addr_stable", stable, 1'b1);
        chk("wr_single_read", rd_q.size(), 1);
        chk("wr_req_dropped", req_dropped, 1'b1);
        chk("wr_pending_served", {data_bus_select, busy, 32'(dv_count - dvb)},
            {1'b1, 1'b0, 32'd1});

        // restart while the read is in WAIT_DATA.
        lat = 4;
        rd_q.delete();
        dvb = dv_count;
        sample_req = 1'b1;
        @(negedge fast_clock);
        sample_req = 1'b0;
        @(negedge fast_clock);
        restart_pulse(1'b0);
        repeat (8) @(negedge fast_clock);
        chk("disc_no_valid", dv_count - dvb, 0);
        chk("disc_dropped_cleared", req_dropped, 1'b0);
        chk("disc_data_kept", read_data, W0);
        chk("disc_read_addr", {32'(rd_q.size()), rd_q[0]}, {32'd1, 23'd1});

        // restart and sample_req together: restart wins.
        lat = 1;
        rd_q.delete();
        sample_req = 1'b1;
        restart    = 1'b1;
        @(negedge fast_clock);
        sample_req = 1'b0;
        restart    = 1'b0;
        repeat (3) @(negedge fast_clock);
        chk("rst_req_no_read", {32'(rd_q.size()), busy}, {32'd0, 1'b0});
        req_pulse(1'b0);
        chk("rst_start_addr", {32'(rd_q.size()), rd_q[0], read_data}, {32'd1, 23'd0, W0});

`ifdef FLASH_READ_TIMEOUT_EN
        lat = 0;
        restart_pulse(1'b0);
        rd_q.delete();
        sample_req = 1'b1;
        @(negedge fast_clock);
        sample_req = 1'b0;
        rd_cyc = 0;
        for (int n = 0; n < 40 && !data_valid; n++) begin
            @(negedge fast_clock);
            rd_cyc++;
        end
        chk("tmo_latency", (rd_cyc >= 9 && rd_cyc <= 12), 1'b1);
        chk("tmo_data_err", {read_data, timeout_err}, {32'h0, 1'b1});
        @(negedge fast_clock);
        lat = 1;
        req_pulse(1'b0);
        req_pulse(1'b0);
        chk("tmo_addr_adv", {32'(rd_q.size()), rd_q[1]}, {32'd2, 23'd1});
        restart_pulse(1'b0);
        chk("tmo_err_cleared", timeout_err, 1'b0);
`endif

        // Reset asserted mid-read; the late data beat must be ignored.
        lat = 3;
        dvb = dv_count;
        sample_req = 1'b1;
        @(negedge fast_clock);
        sample_req = 1'b0;
        @(negedge fast_clock);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_idle", {busy, flash_mem_read, data_valid, read_data}, '0);
        @(negedge fast_clock);
        reset_n = 1'b1;
        repeat (6) @(negedge fast_clock);
        chk("rst_mid_ignored", {32'(dv_count - dvb), read_data, busy}, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
